// File: rtl/aud_pkg.sv
// aud_pkg: constants and state encoding shared by the audio
// recorder and the playback DSP.
package aud_pkg;

  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_L,
    ST_SKIP,
    ST_SHIFT,
    ST_WRITE,
    ST_PAUSE
  } aud_state_e;

endpackage

// File: rtl/aud_rec_writer_deser.sv
// aud_i2s_deser: LRCK fall detect, serial data register, MSB-first
// shift register and bit counter with a last-bit word_valid pulse.
module aud_i2s_deser
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrck,
  input  logic              i_sdata,
  input  logic              i_shift_en,
  output logic              o_lrck_fall,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic              lrck_q;
  logic              sd_q;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // sd_q trails the line by one edge, so the SKIP edge lands on the
  // I2S delay slot and SHIFT edges collect MSB..LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q <= 1'b0;
      sd_q   <= 1'b0;
      sr     <= '0;
      cnt    <= '0;
    end else begin
      lrck_q <= i_lrck;
      sd_q   <= i_sdata;
      if (i_shift_en) begin
        sr  <= o_word;
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_lrck_fall  = lrck_q & ~i_lrck;
  assign o_word       = {sr[DATA_W-2:0], sd_q};
  assign o_word_valid = i_shift_en &&
                        (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/aud_rec_writer.sv
// aud_rec_writer: records the I2S left channel into SRAM.
// Define AUD_REC_LEVEL_EN to add the o_level peak meter.
module aud_rec_writer
  import aud_pkg::*;
#(
  parameter int ADDR_W = AUD_ADDR_W,
  parameter int DATA_W = AUD_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_adclrck,
  input  logic              i_adc_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_data,
  output logic              o_sram_we_n,
  output logic [ADDR_W:0]   o_rec_len,
  output logic              o_full,
  output logic              o_busy
`ifdef AUD_REC_LEVEL_EN
  ,
  output logic [DATA_W-1:0] o_level
`endif
);

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  aud_state_e        state;
  aud_state_e        nxt;
  logic              lrck_fall;
  logic              word_valid;
  logic              shift_en;
  logic              start_go;
  logic              write_done;
  logic              at_max;
  logic [DATA_W-1:0] word;

  assign shift_en   = (state == ST_SHIFT);
  assign at_max     = (o_sram_addr == MAX_ADDR);
  assign start_go   = (state == ST_IDLE) && (nxt == ST_WAIT_L);
  assign write_done = (state == ST_WRITE);
  assign o_busy     = (state != ST_IDLE);

  aud_i2s_deser #(
    .DATA_W (DATA_W)
  ) u_deser (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_lrck       (i_adclrck),
    .i_sdata      (i_adc_data),
    .i_shift_en   (shift_en),
    .o_lrck_fall  (lrck_fall),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (i_start) nxt = ST_WAIT_L;
      ST_WAIT_L: begin
        if (i_pause)        nxt = ST_PAUSE;
        else if (lrck_fall) nxt = ST_SKIP;
      end
      ST_SKIP:   nxt = ST_SHIFT;
      ST_SHIFT:  if (word_valid) nxt = ST_WRITE;
      ST_WRITE:  nxt = at_max ? ST_IDLE : ST_WAIT_L;
      ST_PAUSE:  if (!i_pause) nxt = ST_WAIT_L;
      default:   nxt = ST_IDLE;
    endcase
    // stop overrides everything and also blocks a start in IDLE
    if (i_stop) nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_sram_we_n <= 1'b1;
      o_sram_addr <= '0;
      o_sram_data <= '0;
      o_rec_len   <= '0;
      o_full      <= 1'b0;
    end else begin
      state       <= nxt;
      o_sram_we_n <= (nxt != ST_WRITE);
      if (nxt == ST_WRITE) o_sram_data <= word;
      unique case (1'b1)
        start_go: begin
          o_sram_addr <= '0;
          o_rec_len   <= '0;
          o_full      <= 1'b0;
        end
        write_done: begin
          o_rec_len <= o_rec_len + LEN_ONE;
          if (at_max) o_full <= 1'b1;
          else        o_sram_addr <= o_sram_addr + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef AUD_REC_LEVEL_EN
  logic [DATA_W-1:0] mag;

  // only the most negative code still has its MSB set after negation
  always_comb begin
    mag = word[DATA_W-1] ? (~word + DATA_W'(1)) : word;
    if (mag[DATA_W-1]) mag = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level <= '0;
    end else if (start_go) begin
      o_level <= '0;
    end else if (nxt == ST_WRITE && mag > o_level) begin
      o_level <= mag;
    end
  end
`endif

endmodule

// File: tb/tb_aud_rec_writer.sv
// tb_aud_rec_writer: directed I2S frames with a write scoreboard
// for a default recorder and a 4-word (MAX_ADDR=3) recorder.
module tb_aud_rec_writer;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_start = 1'b0;
  logic          b_start = 1'b0;
  logic          pause = 1'b0;
  logic          stop = 1'b0;
  logic          lrck = 1'b1;
  logic          sdata = 1'b0;

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_we_n, b_we_n;
  logic [AW:0]   a_len, b_len;
  logic          a_full, b_full;
  logic          a_busy, b_busy;
`ifdef AUD_REC_LEVEL_EN
  logic [DW-1:0] a_level, b_level;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] qa_addr[$];
  logic [DW-1:0] qa_data[$];
  logic [DW-1:0] qa_lvl[$];
  logic [AW-1:0] qb_addr[$];
  logic [DW-1:0] qb_data[$];
  logic [DW-1:0] peak = '0;
  logic          a_prev_we = 1'b1;
  logic          b_prev_we = 1'b1;

  aud_rec_writer u_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (a_start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_adclrck   (lrck),
    .i_adc_data  (sdata),
    .o_sram_addr (a_addr),
    .o_sram_data (a_data),
    .o_sram_we_n (a_we_n),
    .o_rec_len   (a_len),
    .o_full      (a_full),
    .o_busy      (a_busy)
`ifdef AUD_REC_LEVEL_EN
    ,
    .o_level     (a_level)
`endif
  );

  aud_rec_writer #(
    .MAX_ADDR (20'd3)
  ) u_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (b_start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_adclrck   (lrck),
    .i_adc_data  (sdata),
    .o_sram_addr (b_addr),
    .o_sram_data (b_data),
    .o_sram_we_n (b_we_n),
    .o_rec_len   (b_len),
    .o_full      (b_full),
    .o_busy      (b_busy)
`ifdef AUD_REC_LEVEL_EN
    ,
    .o_level     (b_level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mag_sat(input logic [DW-1:0] w);
    if (w == 16'h8000) return 16'h7FFF;
    if (w[DW-1])       return 16'h0000 - w;
    return w;
  endfunction

  task automatic exp_a(input logic [AW-1:0] ad,
                       input logic [DW-1:0] d);
    if (mag_sat(d) > peak) peak = mag_sat(d);
    qa_addr.push_back(ad);
    qa_data.push_back(d);
    qa_lvl.push_back(peak);
  endtask

  // scoreboard: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (a_we_n === 1'b0) begin
      chk("a_we_one_cycle", 32'(a_prev_we), 32'd1);
      chk("a_write_expected", 32'(qa_addr.size() != 0), 32'd1);
      if (qa_addr.size() != 0) begin
        chk("a_wr_addr", 32'(a_addr), 32'(qa_addr.pop_front()));
        chk("a_wr_data", 32'(a_data), 32'(qa_data.pop_front()));
`ifdef AUD_REC_LEVEL_EN
        chk("a_level", 32'(a_level), 32'(qa_lvl[0]));
`endif
        void'(qa_lvl.pop_front());
      end
    end
    a_prev_we <= a_we_n;
  end

  always @(negedge clk) begin
    if (b_we_n === 1'b0) begin
      chk("b_we_one_cycle", 32'(b_prev_we), 32'd1);
      chk("b_write_expected", 32'(qb_addr.size() != 0), 32'd1);
      if (qb_addr.size() != 0) begin
        chk("b_wr_addr", 32'(b_addr), 32'(qb_addr.pop_front()));
        chk("b_wr_data", 32'(b_data), 32'(qb_data.pop_front()));
      end
    end
    b_prev_we <= b_we_n;
  end

  // one 40-bit I2S frame: left half bits 0..19, right half 20..39
  task automatic send_frame(input logic [DW-1:0] l,
                            input logic [DW-1:0] r,
                            input int stop_at = -1,
                            input int pon = -1,
                            input int poff = -1,
                            input int rst_at = -1);
    logic [DW-1:0] w;
    int j;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stop_at >= 0 && i == stop_at + 1) begin
        chk("stop_idle_next", 32'(a_busy), 32'd0);
        stop = 1'b0;
      end
      if (rst_at >= 0 && i == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_async", 32'(a_we_n), 32'd1);
        chk("rst_addr_async", 32'(a_addr), 32'd0);
      end
      if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
      if (i == stop_at) stop = 1'b1;
      if (i == pon) pause = 1'b1;
      if (i == poff) pause = 1'b0;
      w = (i < 20) ? l : r;
      j = i % 20;
      lrck = (i >= 20);
      sdata = (j >= 1 && j <= 16) ? w[16-j] : 1'b0;
    end
  endtask

  task automatic start_a();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    peak = '0;
    chk("start_busy", 32'(a_busy), 32'd1);
    chk("start_len", 32'(a_len), 32'd0);
    chk("start_addr", 32'(a_addr), 32'd0);
    chk("start_full", 32'(a_full), 32'd0);
`ifdef AUD_REC_LEVEL_EN
    chk("start_level", 32'(a_level), 32'd0);
`endif
  endtask

  initial begin
    logic [DW-1:0] w;
    repeat (3) @(negedge clk);
    chk("rst_we_n", 32'(a_we_n), 32'd1);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_len", 32'(a_len), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // two left words, right channel all ones never written
    start_a();
    exp_a(20'd0, 16'hA5C3);
    send_frame(16'hA5C3, 16'hFFFF);
    exp_a(20'd1, 16'h0001);
    send_frame(16'h0001, 16'hFFFF);
    chk("len_two", 32'(a_len), 32'd2);

    // stop at bit 8 of SHIFT discards the partial word
    send_frame(16'h5555, 16'hFFFF, 10);
    chk("stop_len", 32'(a_len), 32'd2);
    chk("stop_addr", 32'(a_addr), 32'd2);
    chk("stop_data_held", 32'(a_data), 32'h0001);

    // pause raised mid-word: word 3 still lands, then PAUSE
    start_a();
    exp_a(20'd0, 16'h0F0F);
    send_frame(16'h0F0F, 16'hFFFF);
    exp_a(20'd1, 16'h3C3C);
    send_frame(16'h3C3C, 16'hFFFF);
    exp_a(20'd2, 16'h7001);
    send_frame(16'h7001, 16'hFFFF);
    exp_a(20'd3, 16'hC00D);
    send_frame(16'hC00D, 16'hFFFF, -1, 6);
    chk("pause_busy", 32'(a_busy), 32'd1);
    chk("pause_len", 32'(a_len), 32'd4);
    send_frame(16'hBEEF, 16'hFFFF, -1, -1, 30);
    chk("pause_no_write", 32'(a_len), 32'd4);
    exp_a(20'd4, 16'h1234);
    send_frame(16'h1234, 16'h0000);
    chk("resume_len", 32'(a_len), 32'd5);
    chk("resume_addr", 32'(a_addr), 32'd5);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_idle", 32'(a_busy), 32'd0);

    // 4-word memory: writes 0..3, then full and no fifth write
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_start_busy", 32'(b_busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      w = 16'h1000 + DW'(k);
      if (k < 4) begin
        qb_addr.push_back(AW'(k));
        qb_data.push_back(w);
      end
      send_frame(w, 16'hFFFF);
    end
    chk("b_full", 32'(b_full), 32'd1);
    chk("b_idle", 32'(b_busy), 32'd0);
    chk("b_len", 32'(b_len), 32'd4);
    chk("b_addr_no_wrap", 32'(b_addr), 32'd3);
    chk("a_len_held", 32'(a_len), 32'd5);
    chk("a_data_held", 32'(a_data), 32'h1234);

`ifdef AUD_REC_LEVEL_EN
    start_a();
    exp_a(20'd0, 16'h0100);
    send_frame(16'h0100, 16'hFFFF);
    exp_a(20'd1, 16'h8000);
    send_frame(16'h8000, 16'hFFFF);
    exp_a(20'd2, 16'h0200);
    send_frame(16'h0200, 16'hFFFF);
    chk("level_final", 32'(a_level), 32'h7FFF);
`endif

    // reset asserted while the strobe is low
    start_a();
    exp_a(20'd0, 16'h4321);
    send_frame(16'h4321, 16'hFFFF, -1, -1, -1, 18);
    chk("post_rst_len", 32'(a_len), 32'd0);
    chk("post_rst_busy", 32'(a_busy), 32'd0);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 32'(qa_addr.size()), 32'd0);
    chk("b_queue_empty", 32'(qb_addr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
